mux_n_1_seq: RTL and testbench

- Parametrised N-to-1, W-bit multiplexer with one registered output stage and a valid/ready handshake. It is the successor to the fixed 7:1 single-bit combinational multiplexer tree.
- Two selection modes: manual, where the select comes from the `sel` port, and scan, where an internal round-robin pointer steps through channels 0..N-1.
- Sits between a bank of sampled sources and a single serial consumer.

---
 rtl/mux_n_1_pkg.sv | 18 +
 rtl/mux_n_1_comb.sv | 30 +++
 rtl/mux_n_1_seq.sv | 122 ++++++++++++
 tb/tb_mux_n_1_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mux_n_1_pkg.sv
// Shared types and helpers for the N:1 sequential multiplexer family.
package mux_n_1_pkg;

  // Largest channel count the multiplexer is meant to be built with.
  localparam int MAX_N = 64;

  // Selection mode, sampled per accepted transaction.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_comb.sv
// Purely combinational N:1, W-bit selector. Indices at or above N select zero.
module mux_n_1_comb #(
  parameter int N    = 7,
  parameter int W    = 1,
  parameter int SELW = 3
) (
  input  logic [N*W-1:0] data,
  input  logic [SELW-1:0] idx,
  output logic [W-1:0]   y
);

  // Each channel contributes its sample only when its index matches.
  logic [W-1:0] masked [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign masked[gi] = (idx == SELW'(gi)) ? data[gi*W +: W] : '0;
    end
  endgenerate

  // OR-reduce the one-hot-masked channels; no match leaves the result zero.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      y = y | masked[i];
    end
  end

endmodule

// File: rtl/mux_n_1_seq.sv
// Registered N:1, W-bit multiplexer with valid/ready handshake and
// manual / round-robin scan selection.
// Optional build macro MUX_N_1_SEQ_OOR_FLAG_EN adds a sticky err_oor output
// for out-of-range manual selects and reports index N-1 for such samples.
module mux_n_1_seq
  import mux_n_1_pkg::*;
#(
  parameter  int N    = 7,
  parameter  int W    = 1,
  localparam int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  data,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            scan_restart,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_idx,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
  ,
  output logic            err_oor
`endif
);

  logic [SELW-1:0] ptr_reg, ptr_next;
  logic [W-1:0]    y_reg, y_next;
  logic [SELW-1:0] y_idx_reg, y_idx_next;
  logic            out_valid_reg, out_valid_next;

  logic            accept;
  logic            is_scan;
  logic [SELW-1:0] eff;
  logic [W-1:0]    sel_data;

  assign is_scan  = (mode_e'(mode) == MODE_SCAN);
  assign eff      = is_scan ? ptr_reg : sel;
  // Ready whenever the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  mux_n_1_comb #(
    .N    (N),
    .W    (W),
    .SELW (SELW)
  ) u_comb (
    .data (data),
    .idx  (eff),
    .y    (sel_data)
  );

`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
  logic err_reg, err_next;
  logic sel_oor;

  assign sel_oor = !is_scan && (32'(sel) >= 32'(N));
  assign err_oor = err_reg;
`endif

  // Scan pointer: restart wins over the wrap-at-N-1 increment.
  always_comb begin
    ptr_next = ptr_reg;
    if (scan_restart) begin
      ptr_next = '0;
    end else if (accept && is_scan) begin
      ptr_next = (ptr_reg == SELW'(N - 1)) ? '0 : ptr_reg + 1'b1;
    end
  end

  // Output stage: load on accept, clear valid on a drain, otherwise hold.
  always_comb begin
    y_next         = y_reg;
    y_idx_next     = y_idx_reg;
    out_valid_next = out_valid_reg;
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
    err_next       = err_reg;
`endif
    if (accept) begin
      y_next         = sel_data;
      y_idx_next     = eff;
      out_valid_next = 1'b1;
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
      if (sel_oor) begin
        y_idx_next = SELW'(N - 1);
        err_next   = 1'b1;
      end
`endif
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      y_reg         <= '0;
      y_idx_reg     <= '0;
      out_valid_reg <= 1'b0;
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      ptr_reg       <= ptr_next;
      y_reg         <= y_next;
      y_idx_reg     <= y_idx_next;
      out_valid_reg <= out_valid_next;
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
      err_reg       <= err_next;
`endif
    end
  end

  assign y         = y_reg;
  assign y_idx     = y_idx_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_n_1_seq.sv
// Directed self-checking bench for mux_n_1_seq with N=7, W=8.
module tb_mux_n_1_seq;

  localparam int N    = 7;
  localparam int W    = 8;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  data;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            scan_restart;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    y;
  logic [SELW-1:0] y_idx;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
  logic            err_oor;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  mux_n_1_seq #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .sel          (sel),
    .mode         (mode),
    .scan_restart (scan_restart),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .y            (y),
    .y_idx        (y_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
    ,
    .err_oor      (err_oor)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and report the cycle's outcome on one line.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    $display("cyc %0d: rst=%0b mode=%0b sel=%0d in_valid=%0b out_ready=%0b -> out_valid=%0b y=%02h y_idx=%0d",
             cyc_n, rst, mode, sel, in_valid, out_ready, out_valid, y, y_idx);
  endtask

  initial begin
    for (int i = 0; i < N; i++) data[i*W +: W] = 8'h10 + 8'(i);
    rst = 1'b1; sel = '0; mode = 1'b0; scan_restart = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_idx", 32'(y_idx), 0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // Manual select of channel 3, then drain.
    mode = 1'b0; sel = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("man_valid", 32'(out_valid), 1);
    check("man_y", 32'(y), 32'h13);
    check("man_idx", 32'(y_idx), 3);
    tick();
    check("drain_valid", 32'(out_valid), 0);
    check("drain_y_hold", 32'(y), 32'h13);

    // Scan for 9 back-to-back accepts: indices wrap at 6.
    mode = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("scan_valid", 32'(out_valid), 1);
      check("scan_idx", 32'(y_idx), 32'(k % 7));
      check("scan_y", 32'(y), 32'h10 + 32'(k % 7));
    end

    // Backpressure: held output idx 1, no accept for 3 cycles.
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_ready", 32'(in_ready), 0);
      check("bp_idx", 32'(y_idx), 1);
      check("bp_y", 32'(y), 32'h11);
      check("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    tick();
    check("bp_next_idx", 32'(y_idx), 2);
    check("bp_next_y", 32'(y), 32'h12);
    check("bp_next_valid", 32'(out_valid), 1);

    // Advance to ptr=4, then restart together with a scan accept.
    tick();
    check("pre_rs_idx", 32'(y_idx), 3);
    scan_restart = 1'b1;
    tick();
    scan_restart = 1'b0;
    check("rs_idx_old", 32'(y_idx), 4);
    tick();
    check("rs_idx_zero", 32'(y_idx), 0);
    check("rs_y_zero", 32'(y), 32'h10);

    // Mode switch on consecutive accepts; manual leaves ptr untouched.
    mode = 1'b0; sel = 3'd5;
    tick();
    check("sw_man_idx", 32'(y_idx), 5);
    check("sw_man_y", 32'(y), 32'h15);
    mode = 1'b1;
    tick();
    check("sw_scan_idx", 32'(y_idx), 1);
    check("sw_scan_y", 32'(y), 32'h11);

    // Out-of-range manual select.
    mode = 1'b0; sel = 3'd7;
    tick();
    check("oor_y", 32'(y), 0);
    check("oor_valid", 32'(out_valid), 1);
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
    check("oor_idx", 32'(y_idx), 6);
    check("oor_err", 32'(err_oor), 1);
`else
    check("oor_idx", 32'(y_idx), 7);
`endif
    sel = 3'd2;
    tick();
    check("post_oor_y", 32'(y), 32'h12);
    check("post_oor_idx", 32'(y_idx), 2);
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
    check("err_sticky", 32'(err_oor), 1);
`endif

    // Bring ptr to 5 (accept idx 2,3,4), stall, then reset mid-stall.
    mode = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_idx", 32'(y_idx), 4);
    out_ready = 1'b0;
    tick();
    check("stall_idx", 32'(y_idx), 4);
    check("stall_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_idx", 32'(y_idx), 0);
`ifdef MUX_N_1_SEQ_OOR_FLAG_EN
    check("mid_rst_err", 32'(err_oor), 0);
`endif
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("after_rst_idx", 32'(y_idx), 0);
    check("after_rst_y", 32'(y), 32'h10);
    check("after_rst_valid", 32'(out_valid), 1);
    tick();
    check("final_drain", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
